// File: rtl/kmeans_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : kmeans_seq_ctrl_if
//  Purpose  : Bundles the control, status and strobe signals that run between
//             the k-means iteration sequencer and its surroundings (register
//             file / go logic, RAM, classify pipe, new-means divider and
//             convergence check).
//  Modports : master - the sequencer (consumes requests and results, drives
//                      addresses and strobes)
//             slave  - the environment (drives requests and results,
//                      consumes addresses and strobes)
//  Signals  : go, abort, irq_ack, first_addr, last_addr, max_iter,
//             has_converged, cnvrg_valid                 (toward sequencer)
//             reg_num, reg_write, ram_addr, ram_rd_en, cent_wr_en,
//             first_iter, acc_clr, acc_en, div_en, cnvrg_clr, cnvrg_en,
//             busy, irq, irq_status, iter_count          (from sequencer)
//  Revision : 1.0 - initial release
// ============================================================================
interface kmeans_seq_ctrl_if #(
    parameter int CENT_NUM = 8,
    parameter int ADDR_W   = 9,
    parameter int REG_W    = 4,
    parameter int ITER_W   = 10
);
    // Requests and results toward the sequencer
    logic              go;
    logic              abort;
    logic              irq_ack;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [ITER_W-1:0] max_iter;
    logic              has_converged;
    logic              cnvrg_valid;

    // Addresses, strobes and status from the sequencer
    logic [REG_W-1:0]    reg_num;
    logic                reg_write;
    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_rd_en;
    logic [CENT_NUM-1:0] cent_wr_en;
    logic                first_iter;
    logic                acc_clr;
    logic                acc_en;
    logic                div_en;
    logic                cnvrg_clr;
    logic                cnvrg_en;
    logic                busy;
    logic                irq;
    logic [1:0]          irq_status;
    logic [ITER_W-1:0]   iter_count;

    modport master (
        input  go, abort, irq_ack, first_addr, last_addr, max_iter,
               has_converged, cnvrg_valid,
        output reg_num, reg_write, ram_addr, ram_rd_en, cent_wr_en,
               first_iter, acc_clr, acc_en, div_en, cnvrg_clr, cnvrg_en,
               busy, irq, irq_status, iter_count
    );

    modport slave (
        output go, abort, irq_ack, first_addr, last_addr, max_iter,
               has_converged, cnvrg_valid,
        input  reg_num, reg_write, ram_addr, ram_rd_en, cent_wr_en,
               first_iter, acc_clr, acc_en, div_en, cnvrg_clr, cnvrg_en,
               busy, irq, irq_status, iter_count
    );
endinterface
`default_nettype wire

// File: rtl/kmeans_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : kmeans_seq_ctrl
//  Purpose  : k-means iteration sequencer. Loads the initial centroids from
//             the register file, streams the RAM point range through the
//             classify pipe, runs the divider and the convergence sampling,
//             repeats until converged / iteration limit, then writes the
//             final centroids back and raises a sticky interrupt with a
//             status code. Supports abort and range-error reporting.
//  Ports    : clk  - clock
//             rst  - synchronous reset, active-high
//             bus  - kmeans_seq_ctrl_if.master (all control/status signals)
//  Revision : 1.0 - initial release
// ============================================================================
module kmeans_seq_ctrl #(
    parameter int CENT_NUM   = 8,
    parameter int CENT_W     = 3,
    parameter int ADDR_W     = 9,
    parameter int REG_W      = 4,
    parameter int CENT_BASE  = 2,
    parameter int PIPE_DEPTH = 2,
    parameter int DIV_LAT    = 1,
    parameter int ITER_W     = 10
) (
    input logic               clk,
    input logic               rst,
    kmeans_seq_ctrl_if.master bus
);

    // Phase counter must hold CENT_NUM-1, PIPE_DEPTH-1 and DIV_LAT-1
    localparam int c_PD_W   = $clog2(PIPE_DEPTH + 1);
    localparam int c_DL_W   = $clog2(DIV_LAT + 1);
    localparam int c_CNT_W0 = (CENT_W > c_PD_W) ? CENT_W : c_PD_W;
    localparam int c_CNT_W  = (c_CNT_W0 > c_DL_W) ? c_CNT_W0 : c_DL_W;

    localparam logic [c_CNT_W-1:0] c_CENT_LAST = c_CNT_W'(CENT_NUM - 1);
    localparam logic [c_CNT_W-1:0] c_PIPE_LAST = c_CNT_W'(PIPE_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LAST  = c_CNT_W'(DIV_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [REG_W-1:0]   c_REG_BASE  = REG_W'(CENT_BASE);
    localparam logic [CENT_NUM-1:0] c_ONEHOT0  = CENT_NUM'(1);

    localparam logic [3:0] c_ST_IDLE   = 4'd0;
    localparam logic [3:0] c_ST_LOAD   = 4'd1;
    localparam logic [3:0] c_ST_STREAM = 4'd2;
    localparam logic [3:0] c_ST_DRAIN  = 4'd3;
    localparam logic [3:0] c_ST_DIVIDE = 4'd4;
    localparam logic [3:0] c_ST_CHECK  = 4'd5;
    localparam logic [3:0] c_ST_WAITC  = 4'd6;
    localparam logic [3:0] c_ST_WB     = 4'd7;
    localparam logic [3:0] c_ST_IRQ    = 4'd8;

    localparam logic [1:0] c_STAT_CONV  = 2'b00;
    localparam logic [1:0] c_STAT_MAXIT = 2'b01;
    localparam logic [1:0] c_STAT_ABORT = 2'b10;
    localparam logic [1:0] c_STAT_RANGE = 2'b11;

    // State and counters
    logic [3:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;

    // Registered outputs
    logic [REG_W-1:0]    r_reg_num;
    logic                r_reg_write;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic                r_ram_rd_en;
    logic [CENT_NUM-1:0] r_cent_wr_en;
    logic                r_first_iter;
    logic                r_acc_clr;
    logic                r_div_en;
    logic                r_cnvrg_clr;
    logic                r_cnvrg_en;
    logic                r_busy;
    logic                r_irq;
    logic [1:0]          r_irq_status;
    logic [ITER_W-1:0]   r_iter_count;
    logic [PIPE_DEPTH-1:0] r_pipe;

    // Next-state / next-output values
    logic [3:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [ITER_W-1:0]   w_iter_nxt;
    logic [ITER_W-1:0]   w_iter_inc;
    logic [1:0]          w_status_nxt;
    logic                w_first_nxt;
    logic [CENT_W-1:0]   w_k;
    logic [REG_W-1:0]    w_reg_num_nxt;
    logic                w_reg_write_nxt;
    logic                w_ram_rd_en_nxt;
    logic [CENT_NUM-1:0] w_cent_wr_en_nxt;
    logic                w_acc_clr_nxt;
    logic                w_div_en_nxt;
    logic                w_cnvrg_clr_nxt;
    logic                w_cnvrg_en_nxt;
    logic                w_busy_nxt;
    logic                w_irq_nxt;
    logic                w_in_run;
    logic                w_abort;

    assign w_in_run   = (r_state != c_ST_IDLE) && (r_state != c_ST_IRQ);
    assign w_abort    = w_in_run && bus.abort;
    assign w_iter_inc = (&r_iter_count) ? r_iter_count : r_iter_count + ITER_W'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_addr_nxt   = r_ram_addr;
        w_iter_nxt   = r_iter_count;
        w_status_nxt = r_irq_status;
        w_first_nxt  = r_first_iter;

        case (r_state)
            c_ST_IDLE: begin
                if (bus.go && !r_irq) begin
                    w_iter_nxt   = '0;
                    w_first_nxt  = 1'b1;
                    w_cnt_nxt    = '0;
                    if (bus.first_addr > bus.last_addr) begin
                        w_state_nxt  = c_ST_IRQ;
                        w_status_nxt = c_STAT_RANGE;
                    end else begin
                        w_state_nxt  = c_ST_LOAD;
                        w_status_nxt = c_STAT_CONV;
                    end
                end
            end
            c_ST_LOAD: begin
                if (r_cnt == c_CENT_LAST) begin
                    w_state_nxt = c_ST_STREAM;
                    w_cnt_nxt   = '0;
                    w_addr_nxt  = bus.first_addr;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_ST_STREAM: begin
                // The address itself tracks progress; last_addr is inclusive
                if (r_ram_addr == bus.last_addr) begin
                    w_state_nxt = c_ST_DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_addr_nxt = r_ram_addr + ADDR_W'(1);
                end
            end
            c_ST_DRAIN: begin
                if (r_cnt == c_PIPE_LAST) begin
                    w_state_nxt = c_ST_DIVIDE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_ST_DIVIDE: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_state_nxt = c_ST_CHECK;
                    w_cnt_nxt   = '0;
                    w_first_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_ST_CHECK: begin
                if (r_cnt == c_CENT_LAST) begin
                    w_state_nxt = c_ST_WAITC;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_ST_WAITC: begin
                if (bus.cnvrg_valid) begin
                    w_iter_nxt = w_iter_inc;
                    w_cnt_nxt  = '0;
                    if (bus.has_converged) begin
                        w_state_nxt  = c_ST_WB;
                        w_status_nxt = c_STAT_CONV;
                    end else if ((bus.max_iter != '0) && (w_iter_inc == bus.max_iter)) begin
                        w_state_nxt  = c_ST_WB;
                        w_status_nxt = c_STAT_MAXIT;
                    end else begin
                        w_state_nxt = c_ST_STREAM;
                        w_addr_nxt  = bus.first_addr;
                    end
                end
            end
            c_ST_WB: begin
                if (r_cnt == c_CENT_LAST) begin
                    w_state_nxt = c_ST_IRQ;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_ST_IRQ: begin
                if (bus.irq_ack) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Abort overrides every other transition of a running sequence
        if (w_abort) begin
            w_state_nxt  = c_ST_IRQ;
            w_cnt_nxt    = '0;
            w_status_nxt = c_STAT_ABORT;
        end

        // Outputs are decoded from the next state so they line up with it
        // once registered.
        w_k              = w_cnt_nxt[CENT_W-1:0];
        w_reg_num_nxt    = '0;
        w_reg_write_nxt  = 1'b0;
        w_ram_rd_en_nxt  = 1'b0;
        w_cent_wr_en_nxt = '0;
        w_acc_clr_nxt    = 1'b0;
        w_div_en_nxt     = 1'b0;
        w_cnvrg_clr_nxt  = 1'b0;
        w_cnvrg_en_nxt   = 1'b0;
        w_busy_nxt       = (w_state_nxt != c_ST_IDLE) && (w_state_nxt != c_ST_IRQ);
        w_irq_nxt        = (w_state_nxt == c_ST_IRQ);

        case (w_state_nxt)
            c_ST_LOAD: begin
                w_reg_num_nxt    = c_REG_BASE + REG_W'(w_k);
                w_cent_wr_en_nxt = c_ONEHOT0 << w_k;
            end
            c_ST_STREAM: begin
                w_ram_rd_en_nxt = 1'b1;
                // Clear only on entry to a pass, not on every streamed point
                w_acc_clr_nxt   = (r_state != c_ST_STREAM);
            end
            c_ST_DIVIDE: begin
                w_div_en_nxt    = 1'b1;
                w_cnvrg_clr_nxt = (w_cnt_nxt == '0);
            end
            c_ST_CHECK: begin
                w_div_en_nxt     = 1'b1;
                w_cnvrg_en_nxt   = 1'b1;
                w_cent_wr_en_nxt = c_ONEHOT0 << w_k;
            end
            c_ST_WB: begin
                w_reg_write_nxt = 1'b1;
                w_reg_num_nxt   = c_REG_BASE + REG_W'(w_k);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_reg_num    <= '0;
            r_reg_write  <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_rd_en  <= 1'b0;
            r_cent_wr_en <= '0;
            r_first_iter <= 1'b1;
            r_acc_clr    <= 1'b0;
            r_div_en     <= 1'b0;
            r_cnvrg_clr  <= 1'b0;
            r_cnvrg_en   <= 1'b0;
            r_busy       <= 1'b0;
            r_irq        <= 1'b0;
            r_irq_status <= '0;
            r_iter_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_reg_num    <= w_reg_num_nxt;
            r_reg_write  <= w_reg_write_nxt;
            r_ram_addr   <= w_addr_nxt;
            r_ram_rd_en  <= w_ram_rd_en_nxt;
            r_cent_wr_en <= w_cent_wr_en_nxt;
            r_first_iter <= w_first_nxt;
            r_acc_clr    <= w_acc_clr_nxt;
            r_div_en     <= w_div_en_nxt;
            r_cnvrg_clr  <= w_cnvrg_clr_nxt;
            r_cnvrg_en   <= w_cnvrg_en_nxt;
            r_busy       <= w_busy_nxt;
            r_irq        <= w_irq_nxt;
            r_irq_status <= w_status_nxt;
            r_iter_count <= w_iter_nxt;
        end
    end

    // acc_en is the registered read enable delayed by PIPE_DEPTH cycles;
    // an abort flushes whatever reads are still in flight.
    generate
        if (PIPE_DEPTH == 1) begin : g_pipe_single
            always_ff @(posedge clk) begin
                if (rst || w_abort) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= r_ram_rd_en;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk) begin
                if (rst || w_abort) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[PIPE_DEPTH-2:0], r_ram_rd_en};
                end
            end
        end
    endgenerate

    assign bus.reg_num    = r_reg_num;
    assign bus.reg_write  = r_reg_write;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_rd_en  = r_ram_rd_en;
    assign bus.cent_wr_en = r_cent_wr_en;
    assign bus.first_iter = r_first_iter;
    assign bus.acc_clr    = r_acc_clr;
    assign bus.acc_en     = r_pipe[PIPE_DEPTH-1];
    assign bus.div_en     = r_div_en;
    assign bus.cnvrg_clr  = r_cnvrg_clr;
    assign bus.cnvrg_en   = r_cnvrg_en;
    assign bus.busy       = r_busy;
    assign bus.irq        = r_irq;
    assign bus.irq_status = r_irq_status;
    assign bus.iter_count = r_iter_count;

endmodule
`default_nettype wire
